sobel_frame_ctrl: RTL

Frame sequencer for the `sobel` edge-detection datapath. It takes an unpadded raster stream of 8-bit grayscale pixels through a valid/ready handshake and inserts the one-pixel zero border on all four sides. It drives the padded stream into the datapath's `data` input with a shift enable, and marks each cycle that completes a 3x3 window. It then emits a delayed `out_valid` with output coordinates aligned to the datapath result, and pulses `frame_done` once the last result has been issued.

---
 rtl/sobel_frame_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer for the sobel edge-detection datapath.
// Takes an unpadded 8-bit raster stream over valid/ready and adds a one-pixel
// zero border on all four sides. Drives the padded stream into the datapath
// and flags the cycles that complete a 3x3 window. Emits out_valid and result
// coordinates aligned to the datapath latency, then pulses frame_done.
//
// Optional feature: define SOBEL_CTRL_STALLCNT_EN to build the saturating
// pixel-slot stall counter; otherwise stall_cnt is tied to zero.
//
// Internally (nr, nc) is the next padded slot to be emitted. Every output is a
// register, so a slot shows on sob_en/sob_data in the cycle after it is
// emitted. The state reflects the region of the slot that was emitted last.
module sobel_frame_ctrl #(
  parameter int IMG_W     = 480,
  parameter int IMG_H     = 360,
  parameter int CW        = 10,
  parameter int SOBEL_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [7:0]    sob_data,
  output logic          sob_en,
  output logic          win_valid,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAD_TOP = 3'd1,
    BODY    = 3'd2,
    PAD_BOT = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam logic [CW-1:0] ACT_C     = CW'(IMG_W);
  localparam logic [CW-1:0] ACT_R     = CW'(IMG_H);
  localparam logic [CW-1:0] LAST_C    = CW'(IMG_W + 1);
  localparam logic [CW-1:0] LAST_R    = CW'(IMG_H + 1);
  localparam logic [CW-1:0] END_R     = CW'(IMG_H + 2);
  localparam logic [CW-1:0] OUT_C_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] OUT_R_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] WIN_MIN   = CW'(2);
  localparam int            DLY_N     = (SOBEL_LAT == 0) ? 1 : SOBEL_LAT;
  localparam int            TAP       = DLY_N - 1;
  localparam logic [2:0]    DRAIN_INIT = 3'(DLY_N - 1);

  state_t           state;
  logic [CW-1:0]    nr, nc;
  logic [2:0]       drain_cnt;
  logic [DLY_N-1:0] dly;

  logic          launch, in_slots, slots_done, emit, e_act, win_nxt, nxt_act;
  logic [CW-1:0] er, ec, adv_r, adv_c, nxt_r, nxt_c;

  // Slot carries a real pixel (inside the border, BODY rows only).
  function automatic logic is_active(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return (r != '0) && (r <= ACT_R) && (c != '0) && (c <= ACT_C);
  endfunction

  function automatic state_t region_of(input logic [CW-1:0] r);
    if (r == '0)         return PAD_TOP;
    else if (r == LAST_R) return PAD_BOT;
    else                  return BODY;
  endfunction

  // Decide whether a slot is emitted this cycle and where the scan goes next.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    launch     = (state == IDLE) && start && !frame_done;
    in_slots   = (state == PAD_TOP) || (state == BODY) || (state == PAD_BOT);
    slots_done = (nr == END_R);
    er         = launch ? '0 : nr;
    ec         = launch ? '0 : nc;
    e_act      = is_active(er, ec);
    emit       = launch || (in_slots && !slots_done && (!e_act || pix_valid));
    win_nxt    = emit && (er >= WIN_MIN) && (ec >= WIN_MIN);
    if (ec == LAST_C) begin
      adv_r = er + CW'(1);
      adv_c = '0;
    end else begin
      adv_r = er;
      adv_c = ec + CW'(1);
    end
    nxt_r   = emit ? adv_r : nr;
    nxt_c   = emit ? adv_c : nc;
    nxt_act = is_active(nxt_r, nxt_c);
  end

  // Frame FSM, padded-stream outputs, result alignment and coordinates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state      <= IDLE;
      nr         <= '0;
      nc         <= '0;
      drain_cnt  <= '0;
      // NOTE: the latency delay line is reset too, so an aborted frame cannot
      // leak a stale out_valid into the next one.
      dly        <= '0;
      pix_ready  <= 1'b0;
      sob_data   <= 8'h00;
      sob_en     <= 1'b0;
      win_valid  <= 1'b0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pix_ready  <= 1'b0;
      sob_en     <= emit;
      win_valid  <= win_nxt;
      if (emit) sob_data <= e_act ? pix_in : 8'h00;
      nr <= nxt_r;
      nc <= nxt_c;

      dly[0] <= win_nxt;
      for (int i = 1; i < DLY_N; i++) dly[i] <= dly[i-1];
      out_valid <= (SOBEL_LAT == 0) ? win_nxt : dly[TAP];

      if (launch) begin
        out_row <= '0;
        out_col <= '0;
      end else if (out_valid) begin
        if (out_col == OUT_C_MAX) begin
          out_col <= '0;
          out_row <= (out_row == OUT_R_MAX) ? '0 : out_row + CW'(1);
        end else begin
          out_col <= out_col + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (launch) begin
            state     <= PAD_TOP;
            busy      <= 1'b1;
            pix_ready <= nxt_act;
          end
        end
        PAD_TOP, BODY, PAD_BOT: begin
          if (slots_done) begin
            if (SOBEL_LAT == 0) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_INIT;
            end
          end else begin
            pix_ready <= nxt_act;
            if (emit) state <= region_of(er);
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SOBEL_CTRL_STALLCNT_EN
  logic [15:0] stall_q;

  // Count active-slot cycles without input data; saturating, cleared per frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 16'h0000;
    end else if (launch) begin
      stall_q <= 16'h0000;
    end else if (pix_ready && !pix_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
